// File: rtl/fp_acc_pkg.sv
// fp_acc_pkg: states and IEEE-754 single constants shared by the accumulator sequencer
package fp_acc_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;
  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  localparam int FP_W = 1 + EXP_W + MANT_W;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
endpackage

// File: rtl/fp_accum_ctrl.sv
// fp_accum_ctrl: sequences a packet of singles through a start/done adder into one running sum
module fp_accum_ctrl
  import fp_acc_pkg::*;
#(
  parameter int ADD_LAT = 26,
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [FP_W-1:0]  res_data,
  output logic [CNT_W-1:0] res_count,
  output logic             res_err,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [FP_W-1:0]  add_a,
  output logic [FP_W-1:0]  add_b,
  output logic             add_start,
  input  logic [FP_W-1:0]  add_sum,
  input  logic             add_done
);
  localparam int CYC_W = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [FP_W-1:0] acc, opb;
  logic [CNT_W-1:0] count;
  logic [CYC_W-1:0] cyc;
  logic first, err, last_r, take, cap, tmo;
  assign in_ready = state == IDLE;
  assign add_start = state == START;
  assign res_valid = state == OUT;
  assign add_a = acc;
  assign add_b = opb;
  assign res_data = acc;
  assign res_count = count;
  assign res_err = err;
  always_comb begin
    take = in_valid && state == IDLE;
    // done is stale until the adder has had time to clear it after start
    cap = state == WAIT && cyc >= CYC_W'(ADD_LAT - 1) && add_done;
    tmo = state == WAIT && cyc == CYC_W'(TIMEOUT - 1);
    state_n = state;
    case (state)
      IDLE:  state_n = take ? (first ? (in_last ? OUT : IDLE) : START) : IDLE;
      START: state_n = WAIT;
      WAIT:  state_n = (cap || tmo) ? (last_r ? OUT : IDLE) : WAIT;
      OUT:   state_n = res_ready ? IDLE : OUT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      acc <= FP_ZERO;
      opb <= FP_ZERO;
      count <= '0;
      cyc <= '0;
      first <= 1'b1;
      err <= 1'b0;
      last_r <= 1'b0;
    end else begin
      if (take && first) begin
        acc <= in_data;
        count <= CNT_W'(1);
        first <= 1'b0;
      end
      if (take && !first) begin
        opb <= in_data;
        last_r <= in_last;
      end
      if (state == START) cyc <= '0;
      if (state == WAIT) cyc <= cyc + CYC_W'(1);
      if (cap) acc <= add_sum;
      if (cap || tmo) count <= count + CNT_W'(~&count);
      if (tmo && !cap) err <= 1'b1;
      if (state == OUT && res_ready) begin
        first <= 1'b1;
        err <= 1'b0;
        count <= '0;
      end
    end
endmodule
